alsu_cmd_arbiter: RTL and testbench

- Two-requester command front-end for the 3-bit ALSU datapath (`A`, `B`, `opcode`, `cin`, `serial_in`, `direction`, `red_op_A`/`red_op_B`, `bypass_A`/`bypass_B`, 6-bit `out`, 16-bit `leds`).
- Arbitrates requesters and screens illegal commands before issue.
- Drives ALSU control/data inputs from stable registers and waits the ALSU pipeline latency.
- Returns each result with a valid/ready response handshake.
- Sits between the system command bus and the single shared ALSU instance.

---
 rtl/alsu_cmd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alsu_cmd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alsu_cmd_arbiter
//  Purpose  : Two-requester command front-end for the shared 3-bit ALSU.
//             Arbitrates (round-robin or fixed priority), rejects illegal
//             commands, holds ALSU inputs stable for the pipeline latency,
//             and returns the result over a valid/ready response port.
//  Options  : ALSU_ERR_CHECK_EN - when defined, a non-zero alsu_leds value at
//             the result sample edge sets rsp_err.
//  Revision : 1.0 - initial release
// ============================================================================
module alsu_cmd_arbiter #(
    parameter int    ALSU_LATENCY = 2,
    parameter string ARB_MODE     = "RR"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [13:0] req0_cmd,
    input  logic [13:0] req1_cmd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
);

    localparam int                 c_cnt_w = (ALSU_LATENCY < 1) ? 1 : $clog2(ALSU_LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_lat   = c_cnt_w'(ALSU_LATENCY);
    localparam bit                 c_fixed = (ARB_MODE == "FIXED");

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic [c_cnt_w-1:0] r_cnt;

    logic [2:0]         r_alsu_A;
    logic [2:0]         r_alsu_B;
    logic [2:0]         r_alsu_opcode;
    logic               r_alsu_cin;
    logic               r_alsu_serial_in;
    logic               r_alsu_direction;
    logic               r_alsu_red_op_A;
    logic               r_alsu_red_op_B;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [5:0]         r_rsp_data;
    logic               r_rsp_err;

    logic               w_gnt_vld;
    logic               w_gnt_id;
    logic               w_accept;
    logic [13:0]        w_cmd;
    logic               w_illegal;
    logic               w_sample_err;
    logic               w_unused_leds;

    // Pick the winning requester and screen its command.
    always_comb begin
        w_gnt_vld = req0_valid | req1_valid;
        w_gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            // On contention, round-robin hands the grant to whoever did not win last.
            w_gnt_id = c_fixed ? 1'b0 : ~r_last_grant;
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end
        w_accept  = rst & (r_state == ST_IDLE) & w_gnt_vld;
        w_cmd     = w_gnt_id ? req1_cmd : req0_cmd;
        // Opcodes 6/7 are undefined; reduction only applies to AND/XOR.
        w_illegal = (w_cmd[13:11] >= 3'd6) |
                    ((w_cmd[1] | w_cmd[0]) & (w_cmd[13:11] >= 3'd2));
    end

`ifdef ALSU_ERR_CHECK_EN
    assign w_sample_err  = |alsu_leds;
    assign w_unused_leds = 1'b0;
`else
    assign w_sample_err  = 1'b0;
    assign w_unused_leds = ^alsu_leds;
`endif

    // Command FSM: accept/screen in IDLE, wait out the ALSU pipe, hold the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= 1'b1;
            r_cnt            <= '0;
            r_alsu_A         <= '0;
            r_alsu_B         <= '0;
            r_alsu_opcode    <= '0;
            r_alsu_cin       <= 1'b0;
            r_alsu_serial_in <= 1'b0;
            r_alsu_direction <= 1'b0;
            r_alsu_red_op_A  <= 1'b0;
            r_alsu_red_op_B  <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_id         <= 1'b0;
            r_rsp_data       <= '0;
            r_rsp_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_gnt_id;
                        r_rsp_id     <= w_gnt_id;
                        if (w_illegal) begin
                            // Rejected commands never reach the ALSU.
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_alsu_opcode    <= w_cmd[13:11];
                            r_alsu_A         <= w_cmd[10:8];
                            r_alsu_B         <= w_cmd[7:5];
                            r_alsu_cin       <= w_cmd[4];
                            r_alsu_serial_in <= w_cmd[3];
                            r_alsu_direction <= w_cmd[2];
                            r_alsu_red_op_A  <= w_cmd[1];
                            r_alsu_red_op_B  <= w_cmd[0];
                            r_cnt            <= c_lat;
                            r_state          <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= alsu_out;
                        r_rsp_err   <= w_sample_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready     = w_accept & ~w_gnt_id;
    assign req1_ready     = w_accept &  w_gnt_id;
    assign busy           = (r_state != ST_IDLE);

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;

    assign alsu_A         = r_alsu_A;
    assign alsu_B         = r_alsu_B;
    assign alsu_opcode    = r_alsu_opcode;
    assign alsu_cin       = r_alsu_cin;
    assign alsu_serial_in = r_alsu_serial_in;
    assign alsu_direction = r_alsu_direction;
    assign alsu_red_op_A  = r_alsu_red_op_A;
    assign alsu_red_op_B  = r_alsu_red_op_B;
    assign alsu_bypass_A  = 1'b0;
    assign alsu_bypass_B  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alsu_cmd_arbiter
//  Purpose  : Self-checking bench for alsu_cmd_arbiter with a 2-stage ALSU
//             stand-in and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alsu_cmd_arbiter;

    localparam int    LAT  = 2;
    localparam string MODE = "RR";

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [13:0] req0_cmd = '0, req1_cmd = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;
    logic [5:0]  rsp_data;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_direction;
    logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [15:0] alsu_leds = '0;
    logic [5:0]  alsu_s1 = '0, alsu_s2 = '0;
    wire  [5:0]  alsu_out = alsu_s2;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alsu_cmd_arbiter #(.ALSU_LATENCY(LAT), .ARB_MODE(MODE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_direction(alsu_direction), .alsu_red_op_A(alsu_red_op_A),
        .alsu_red_op_B(alsu_red_op_B), .alsu_bypass_A(alsu_bypass_A),
        .alsu_bypass_B(alsu_bypass_B), .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    // ---------------- helpers ----------------
    function automatic logic [13:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                       input logic cin, input logic ser, input logic dir,
                                       input logic ra, input logic rb);
        return {op, a, b, cin, ser, dir, ra, rb};
    endfunction

    // Reference ALSU arithmetic.
    function automatic logic [5:0] alsu_fn(input logic [13:0] c);
        logic [2:0] op, a, b;
        logic [5:0] r;
        op = c[13:11]; a = c[10:8]; b = c[7:5];
        r  = '0;
        case (op)
            3'd0: r = c[1] ? {5'b0, &a} : (c[0] ? {5'b0, &b} : {3'b0, a & b});
            3'd1: r = c[1] ? {5'b0, ^a} : (c[0] ? {5'b0, ^b} : {3'b0, a ^ b});
            3'd2: r = {3'b0, a} + {3'b0, b} + {5'b0, c[4]};
            3'd3: r = {3'b0, a} * {3'b0, b};
            3'd4: r = {3'b0, c[2] ? {a[1:0], c[3]} : {c[3], a[2:1]}};
            3'd5: r = {3'b0, c[2] ? {a[1:0], a[2]} : {a[0], a[2:1]}};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit is_illegal(input logic [13:0] c);
        return (c[13:11] >= 3'd6) || ((c[1] | c[0]) && (c[13:11] >= 3'd2));
    endfunction

    // Returns the index that wins arbitration, or -1 when nobody requests.
    function automatic int model_grant(input logic v0, input logic v1, input logic last);
        if (!v0 && !v1) return -1;
        if (MODE == "FIXED") return v0 ? 0 : 1;
        if (v0 && v1) return last ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ALSU stand-in: two registered stages ----------------
    always @(posedge clk) begin
        alsu_s1 <= alsu_fn({alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
                            alsu_direction, alsu_red_op_A, alsu_red_op_B});
        alsu_s2 <= alsu_s1;
    end

    // ---------------- transaction-level model ----------------
    bit          m_busy, m_resp;
    logic        m_id, m_last, m_err;
    logic [5:0]  m_data;
    logic [13:0] m_drv;
    int          m_due;
    int          w_g;
    logic [13:0] w_gcmd;

    always_comb begin
        w_g    = model_grant(req0_valid, req1_valid, m_last);
        w_gcmd = (w_g == 1) ? req1_cmd : req0_cmd;
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_id <= 1'b0; m_last <= 1'b1;
            m_err <= 1'b0; m_data <= '0; m_drv <= '0; m_due <= 0;
        end else if (!m_busy) begin
            if (w_g >= 0) begin
                m_last <= (w_g == 1);
                m_id   <= (w_g == 1);
                m_busy <= 1'b1;
                if (is_illegal(w_gcmd)) begin
                    m_resp <= 1'b1; m_data <= '0; m_err <= 1'b1;
                end else begin
                    m_drv <= w_gcmd;
                    m_due <= LAT + 1;   // result is taken LAT+1 edges after accept
                end
            end
        end else if (!m_resp) begin
            m_due <= m_due - 1;
            if (m_due == 1) begin
                m_resp <= 1'b1;
                m_data <= alsu_fn(m_drv);
`ifdef ALSU_ERR_CHECK_EN
                m_err  <= (alsu_leds != 16'd0);
`else
                m_err  <= 1'b0;
`endif
            end
        end else if (rsp_ready) begin
            m_resp <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
            check("busy",      {31'b0, busy},      {31'b0, m_busy});
            check("rsp_id",    {31'b0, rsp_id},    {31'b0, m_id});
            check("rsp_data",  {26'b0, rsp_data},  {26'b0, m_data});
            check("rsp_err",   {31'b0, rsp_err},   {31'b0, m_err});
            check("alsu_drive", {18'b0, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
                                 alsu_direction, alsu_red_op_A, alsu_red_op_B}, {18'b0, m_drv});
            check("bypass", {30'b0, alsu_bypass_A, alsu_bypass_B}, 32'd0);
            if (req0_valid)
                check("req0_ready", {31'b0, req0_ready}, {31'b0, (rst && !m_busy && w_g == 0)});
            if (req1_valid)
                check("req1_ready", {31'b0, req1_ready}, {31'b0, (rst && !m_busy && w_g == 1)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int p, input logic [13:0] c);
        bit ok;
        ok = 1'b0;
        if (p == 0) begin req0_valid = 1'b1; req0_cmd = c; end
        else        begin req1_valid = 1'b1; req1_cmd = c; end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Waits for a response; lat counts edges from accept to rsp_valid.
    task automatic wait_rsp(output logic [5:0] d, output logic id, output logic err, output int lat);
        bit got;
        got = 1'b0; lat = -1; d = '0; id = 1'b0; err = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = n - 1; d = rsp_data; id = rsp_id; err = rsp_err;
            end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
        tick();
    endtask

    logic [5:0] d;
    logic       id, er;
    int         lat;
    bit         seen;

    initial begin
        // Reset with a pending request: nothing may be accepted.
        rst = 1'b0; req0_valid = 1'b1; req0_cmd = mk(3'd2, 3'd3, 3'd5, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
            check("rst_outputs", {rsp_valid, busy, rsp_err, rsp_id, rsp_data, alsu_opcode, alsu_A, alsu_B}, 32'd0);
            tick();
        end

        // Single add: 3 + 5 + 1.
        rst = 1'b1;
        send(0, mk(3'd2, 3'd3, 3'd5, 1, 0, 0, 0, 0));
        wait_rsp(d, id, er, lat);
        check("add_data", {26'b0, d}, 32'd9);
        check("add_lat", lat, 32'd3);
        check("add_id_err", {30'b0, id, er}, 32'd0);

        // Contention from reset: req0 mult 7*7, req1 xor 5^3.
        rst = 1'b0;
        req0_valid = 1'b1; req0_cmd = mk(3'd3, 3'd7, 3'd7, 0, 0, 0, 0, 0);
        req1_valid = 1'b1; req1_cmd = mk(3'd1, 3'd5, 3'd3, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b1;
        wait_rsp(d, id, er, lat);
        check("rr_first", {25'b0, id, d}, {25'b0, 1'b0, 6'd49});
        wait_rsp(d, id, er, lat);
        check("rr_second", {25'b0, id, d}, {25'b0, 1'b1, 6'd6});
        wait_rsp(d, id, er, lat);
        check("rr_third", {25'b0, id, d}, {25'b0, 1'b0, 6'd49});
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Illegal: opcode 6 from req1, then reduction on ADD from req0.
        send(1, mk(3'd6, 3'd1, 3'd2, 0, 0, 0, 0, 0));
        wait_rsp(d, id, er, lat);
        check("ill6_rsp", {24'b0, lat[0], id, er, d}, {24'b0, 1'b0, 1'b1, 1'b1, 6'd0});
        check("ill6_lat", lat, 32'd0);
        check("ill6_opcode", {29'b0, alsu_opcode}, 32'd3);
        send(0, mk(3'd2, 3'd1, 3'd1, 0, 0, 0, 1, 0));
        wait_rsp(d, id, er, lat);
        check("illred_rsp", {24'b0, id, er, d}, {24'b0, 1'b0, 1'b1, 6'd0});
        check("illred_lat", lat, 32'd0);
        check("illred_opcode", {29'b0, alsu_opcode}, 32'd3);

        // Backpressure: hold the response while both requesters wait.
        rsp_ready = 1'b0;
        send(0, mk(3'd1, 3'd6, 3'd1, 0, 0, 0, 0, 0));
        req0_valid = 1'b1; req1_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            else tick();
        end
        check("bp_seen", {31'b0, seen}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("bp_hold", {22'b0, rsp_valid, busy, req0_ready, req1_ready, rsp_data},
                             {22'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd7});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", {30'b0, busy, rsp_valid}, 32'd0);
        tick();

        // Reset one cycle after accept: command is abandoned.
        send(0, mk(3'd1, 3'd6, 3'd1, 0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_quiet", {rsp_valid, busy, alsu_opcode, alsu_A, alsu_B}, 32'd0);
            tick();
        end
        send(0, mk(3'd2, 3'd3, 3'd5, 1, 0, 0, 0, 0));
        wait_rsp(d, id, er, lat);
        check("after_rst_add", {24'b0, lat[1:0], d}, {24'b0, 2'd3, 6'd9});

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 79) != 0);
            req0_valid = $urandom_range(0, 1) != 0;
            req1_valid = $urandom_range(0, 1) != 0;
            req0_cmd   = 14'($urandom);
            req1_cmd   = 14'($urandom);
            if ($urandom_range(0, 3) != 0) req0_cmd[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) req1_cmd[1:0] = 2'b00;
            rsp_ready  = $urandom_range(0, 3) != 0;
            alsu_leds  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'd0;
            tick();
        end

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
